// File: rtl/weight_init_pkg.sv
// Shared types and default geometry for the weight RAM initialisation sequencer.
package weight_init_pkg;

   localparam int WIDTH     = 10;
   localparam int ROW_WORDS = 10;
   localparam int NUM_ROWS  = 5;
   localparam int ADDR_W    = 7;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      COLLECT = 3'd1,
      WRITE   = 3'd2,
      DONE    = 3'd3,
      READ    = 3'd4
   } state_t;

   // Base address of a row; the caller widens or narrows to its own address bus.
   function automatic logic [ADDR_W-1:0] row_base(input int row, input int row_words = ROW_WORDS);
      int prod;
      prod = row * row_words;
      return prod[ADDR_W-1:0];
   endfunction

endpackage

// File: rtl/weight_init_ctrl_collector.sv
// Row capture buffer: stores one incoming weight word per load into slot idx.
module weight_row_collector #(
   parameter int WIDTH     = 10,
   parameter int ROW_WORDS = 10,
   localparam int IDX_W    = $clog2(ROW_WORDS)
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       load,
   input  logic [IDX_W-1:0]           idx,
   input  logic [WIDTH-1:0]           data,
   output logic [WIDTH*ROW_WORDS-1:0] row
);

   // Capture the incoming word into the addressed slot.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row <= '0;
      end else if (load) begin
         for (int k = 0; k < ROW_WORDS; k++) begin
            if (idx == IDX_W'(k)) begin
               row[k*WIDTH +: WIDTH] <= data;
            end
         end
      end
   end

endmodule

// File: rtl/weight_init_ctrl.sv
// Weight RAM sequencer: fills the RAM row by row from the LFSR, then serves
// row-read requests from the neuron layer.
module weight_init_ctrl
   import weight_init_pkg::*;
#(
   parameter int WIDTH     = weight_init_pkg::WIDTH,
   parameter int ROW_WORDS = weight_init_pkg::ROW_WORDS,
   parameter int NUM_ROWS  = weight_init_pkg::NUM_ROWS,
   parameter int ADDR_W    = weight_init_pkg::ADDR_W,
   parameter int RD_LAT    = 1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start_init,
   input  logic [WIDTH-1:0]           lfsr_data,
   output logic                       ram_mode,
   output logic                       ram_we,
   output logic [ADDR_W-1:0]          ram_addr,
   output logic [WIDTH*ROW_WORDS-1:0] ram_wdata,
   output logic                       init_busy,
   output logic                       init_done,
   input  logic                       rd_req,
   input  logic [2:0]                 rd_row,
   output logic                       rd_gnt,
   output logic                       rd_valid,
   output logic                       rd_err
);

   localparam int WORD_W = $clog2(ROW_WORDS);
   localparam int ROW_W  = $clog2(NUM_ROWS + 1);
   localparam int LAT_W  = 2;

   if (NUM_ROWS * ROW_WORDS > 2 ** ADDR_W) begin : g_addr_check
      $error("weight_init_ctrl: NUM_ROWS*ROW_WORDS exceeds the RAM address space");
   end
   if (RD_LAT < 1 || RD_LAT > 3) begin : g_lat_check
      $error("weight_init_ctrl: RD_LAT must be in 1..3");
   end

   state_t                     state_r, state_next_s;
   logic [ROW_W-1:0]           row_r, row_next_s;
   logic [WORD_W-1:0]          word_r, word_next_s;
   logic [LAT_W-1:0]           lat_r, lat_next_s;
   logic                       mode_next_s, we_next_s, busy_next_s, done_next_s;
   logic                       gnt_next_s, valid_next_s, err_next_s;
   logic [ADDR_W-1:0]          addr_next_s;
   logic [WIDTH*ROW_WORDS-1:0] wdata_next_s, collect_row_s;

   weight_row_collector #(
      .WIDTH     (WIDTH),
      .ROW_WORDS (ROW_WORDS)
   ) u_collector (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (state_r == COLLECT),
      .idx   (word_r),
      .data  (lfsr_data),
      .row   (collect_row_s)
   );

   // Next-state, counter and output decode.
   always_comb begin
      state_next_s = state_r;
      row_next_s   = row_r;
      word_next_s  = word_r;
      lat_next_s   = lat_r;
      mode_next_s  = ram_mode;
      we_next_s    = 1'b0;
      addr_next_s  = ram_addr;
      wdata_next_s = ram_wdata;
      busy_next_s  = init_busy;
      done_next_s  = init_done;
      gnt_next_s   = 1'b0;
      valid_next_s = 1'b0;
      err_next_s   = 1'b0;
      case (state_r)
         IDLE, DONE: begin
            if (start_init) begin
               state_next_s = COLLECT;
               row_next_s   = '0;
               word_next_s  = '0;
               mode_next_s  = 1'b1;
               busy_next_s  = 1'b1;
               done_next_s  = 1'b0;
            end else if (state_r == DONE && rd_req) begin
               // Out-of-range rows are rejected without touching the held address.
               if (32'(rd_row) < 32'(NUM_ROWS)) begin
                  state_next_s = READ;
                  gnt_next_s   = 1'b1;
                  lat_next_s   = '0;
                  addr_next_s  = ADDR_W'(row_base(int'(rd_row), ROW_WORDS));
               end else begin
                  err_next_s   = 1'b1;
               end
            end else begin
               state_next_s = state_r;
            end
         end
         COLLECT: begin
            if (word_r == WORD_W'(ROW_WORDS - 1)) begin
               // The last word is still on lfsr_data, so merge it into the write row here.
               state_next_s = WRITE;
               word_next_s  = '0;
               we_next_s    = 1'b1;
               addr_next_s  = ADDR_W'(row_base(int'(row_r), ROW_WORDS));
               wdata_next_s = collect_row_s;
               wdata_next_s[(ROW_WORDS-1)*WIDTH +: WIDTH] = lfsr_data;
            end else begin
               word_next_s  = word_r + WORD_W'(1);
            end
         end
         WRITE: begin
            row_next_s = row_r + ROW_W'(1);
            if (row_r == ROW_W'(NUM_ROWS - 1)) begin
               state_next_s = DONE;
               mode_next_s  = 1'b0;
               busy_next_s  = 1'b0;
               done_next_s  = 1'b1;
            end else begin
               state_next_s = COLLECT;
               word_next_s  = '0;
            end
         end
         READ: begin
            if (lat_r == LAT_W'(RD_LAT - 1)) begin
               state_next_s = DONE;
               valid_next_s = 1'b1;
            end else begin
               lat_next_s   = lat_r + LAT_W'(1);
            end
         end
         default: begin
            state_next_s = IDLE;
            mode_next_s  = 1'b1;
            busy_next_s  = 1'b0;
            done_next_s  = 1'b0;
         end
      endcase
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= IDLE;
         row_r     <= '0;
         word_r    <= '0;
         lat_r     <= '0;
         ram_mode  <= 1'b1;
         ram_we    <= 1'b0;
         ram_addr  <= '0;
         ram_wdata <= '0;
         init_busy <= 1'b0;
         init_done <= 1'b0;
         rd_gnt    <= 1'b0;
         rd_valid  <= 1'b0;
         rd_err    <= 1'b0;
      end else begin
         state_r   <= state_next_s;
         row_r     <= row_next_s;
         word_r    <= word_next_s;
         lat_r     <= lat_next_s;
         ram_mode  <= mode_next_s;
         ram_we    <= we_next_s;
         ram_addr  <= addr_next_s;
         ram_wdata <= wdata_next_s;
         init_busy <= busy_next_s;
         init_done <= done_next_s;
         rd_gnt    <= gnt_next_s;
         rd_valid  <= valid_next_s;
         rd_err    <= err_next_s;
      end
   end

endmodule

// File: tb/tb_weight_init_ctrl.sv
// Scoreboard bench for weight_init_ctrl: stimulus pushes expected RAM writes and
// read-handshake events, a negedge monitor pops and compares them.
module tb_weight_init_ctrl;

   localparam int RD_LAT = 1;

   logic         clk;
   logic         rst_n;
   logic         start_init;
   logic [9:0]   lfsr_data;
   logic         ram_mode;
   logic         ram_we;
   logic [6:0]   ram_addr;
   logic [99:0]  ram_wdata;
   logic         init_busy;
   logic         init_done;
   logic         rd_req;
   logic [2:0]   rd_row;
   logic         rd_gnt;
   logic         rd_valid;
   logic         rd_err;

   typedef struct {
      logic [6:0]  addr;
      logic [99:0] data;
      int          cyc;
   } ev_t;

   ev_t  q_wr[$];
   ev_t  q_gnt[$];
   ev_t  q_val[$];
   ev_t  q_err[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc = 0;
   logic [9:0] lfsr_q;

   weight_init_ctrl #(.RD_LAT(RD_LAT)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start_init (start_init),
      .lfsr_data  (lfsr_data),
      .ram_mode   (ram_mode),
      .ram_we     (ram_we),
      .ram_addr   (ram_addr),
      .ram_wdata  (ram_wdata),
      .init_busy  (init_busy),
      .init_done  (init_done),
      .rd_req     (rd_req),
      .rd_row     (rd_row),
      .rd_gnt     (rd_gnt),
      .rd_valid   (rd_valid),
      .rd_err     (rd_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      lfsr_q    = {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[6]};
      lfsr_data = lfsr_q;
   endtask

   task automatic chk_reset_values();
      chk("rst_mode",  ram_mode,  1'b1);
      chk("rst_we",    ram_we,    1'b0);
      chk("rst_addr",  ram_addr,  7'd0);
      chk("rst_wdata", ram_wdata, 100'd0);
      chk("rst_busy",  init_busy, 1'b0);
      chk("rst_done",  init_done, 1'b0);
      chk("rst_gnt",   rd_gnt,    1'b0);
      chk("rst_valid", rd_valid,  1'b0);
      chk("rst_err",   rd_err,    1'b0);
   endtask

   // Full init sequence; abort_at >= 0 returns early in that init cycle.
   task automatic do_init(input bit collide, input int abort_at);
      int          n;
      logic [99:0] row_d;
      n = 0;
      row_d = '0;
      start_init = 1'b1;
      rd_req     = collide;
      rd_row     = 3'd2;
      tick();
      start_init = 1'b0;
      rd_req     = 1'b0;
      chk("init_start_done", init_done, 1'b0);
      chk("init_start_mode", ram_mode,  1'b1);
      chk("init_start_busy", init_busy, 1'b1);
      for (int r = 0; r < 5; r++) begin
         for (int k = 0; k < 10; k++) begin
            if (n == abort_at) return;
            row_d[k*10 +: 10] = lfsr_data;
            tick();
            n++;
         end
         if (n == abort_at) return;
         q_wr.push_back('{addr: 7'(r * 10), data: row_d, cyc: cyc});
         if (r == 4) chk("init_done_in_last_write", init_done, 1'b0);
         tick();
         n++;
      end
      chk("init_done_after", init_done, 1'b1);
      chk("init_busy_after", init_busy, 1'b0);
      chk("init_mode_after", ram_mode,  1'b0);
   endtask

   task automatic do_read(input logic [2:0] row, input bit ok, input logic [6:0] hold_addr);
      rd_row = row;
      rd_req = 1'b1;
      if (ok) begin
         q_gnt.push_back('{addr: 7'(row * 10), data: '0, cyc: cyc + 1});
         q_val.push_back('{addr: 7'(row * 10), data: '0, cyc: cyc + 1 + RD_LAT});
      end else begin
         q_err.push_back('{addr: hold_addr, data: '0, cyc: cyc + 1});
      end
      tick();
      rd_req = 1'b0;
      if (!ok) begin
         chk("err_addr_hold", ram_addr,  hold_addr);
         chk("err_done_hold", init_done, 1'b1);
      end
      repeat (RD_LAT + 2) tick();
   endtask

   task automatic held_read(input logic [2:0] row, input int n);
      rd_row = row;
      rd_req = 1'b1;
      for (int j = 0; j < n; j++) begin
         q_gnt.push_back('{addr: 7'(row * 10), data: '0, cyc: cyc + 1 + j * (RD_LAT + 1)});
         q_val.push_back('{addr: 7'(row * 10), data: '0, cyc: cyc + 1 + j * (RD_LAT + 1) + RD_LAT});
      end
      repeat (n * (RD_LAT + 1)) tick();
      rd_req = 1'b0;
      repeat (RD_LAT + 2) tick();
   endtask

   // Monitor: every output event must match the head of its expectation queue.
   always @(negedge clk) begin
      ev_t e;
      if (ram_we) begin
         if (q_wr.size() == 0) chk("wr_unexpected", 1'b1, 1'b0);
         else begin
            e = q_wr.pop_front();
            chk("wr_addr",  ram_addr,  e.addr);
            chk("wr_data",  ram_wdata, e.data);
            chk("wr_cycle", cyc,       e.cyc);
         end
      end
      if (rd_gnt) begin
         if (q_gnt.size() == 0) chk("gnt_unexpected", 1'b1, 1'b0);
         else begin
            e = q_gnt.pop_front();
            chk("gnt_addr",  ram_addr, e.addr);
            chk("gnt_cycle", cyc,      e.cyc);
            chk("gnt_mode",  ram_mode, 1'b0);
         end
      end
      if (rd_valid) begin
         if (q_val.size() == 0) chk("valid_unexpected", 1'b1, 1'b0);
         else begin
            e = q_val.pop_front();
            chk("valid_addr",  ram_addr, e.addr);
            chk("valid_cycle", cyc,      e.cyc);
         end
      end
      if (rd_err) begin
         if (q_err.size() == 0) chk("err_unexpected", 1'b1, 1'b0);
         else begin
            e = q_err.pop_front();
            chk("err_cycle", cyc, e.cyc);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n      = 1'b0;
      start_init = 1'b0;
      rd_req     = 1'b0;
      rd_row     = 3'd0;
      lfsr_q     = 10'h001;
      lfsr_data  = lfsr_q;
      #50;
      chk_reset_values();
      #50;
      rst_n = 1'b1;
      repeat (2) tick();

      // Requests in IDLE are ignored.
      rd_row = 3'd1;
      rd_req = 1'b1;
      repeat (3) tick();
      rd_row = 3'd6;
      repeat (2) tick();
      rd_req = 1'b0;
      chk("idle_done", init_done, 1'b0);
      chk("idle_busy", init_busy, 1'b0);

      do_init(1'b0, -1);
      do_read(3'd3, 1'b1, 7'd0);
      do_read(3'd5, 1'b0, 7'd30);
      do_read(3'd7, 1'b0, 7'd30);
      do_read(3'd4, 1'b1, 7'd0);

      // start_init while READ is ignored.
      rd_row = 3'd1;
      rd_req = 1'b1;
      q_gnt.push_back('{addr: 7'd10, data: '0, cyc: cyc + 1});
      q_val.push_back('{addr: 7'd10, data: '0, cyc: cyc + 1 + RD_LAT});
      tick();
      rd_req     = 1'b0;
      start_init = 1'b1;
      tick();
      start_init = 1'b0;
      repeat (RD_LAT + 2) tick();
      chk("read_start_done", init_done, 1'b1);
      chk("read_start_busy", init_busy, 1'b0);

      held_read(3'd0, 3);

      do_init(1'b1, -1);
      do_read(3'd2, 1'b1, 7'd0);

      // Reset in the 20th init cycle.
      do_init(1'b0, 19);
      #2;
      rst_n = 1'b0;
      #1;
      chk_reset_values();
      repeat (3) tick();
      rst_n = 1'b1;
      repeat (3) tick();
      chk("post_rst_done", init_done, 1'b0);
      do_init(1'b0, -1);
      do_read(3'd1, 1'b1, 7'd0);

      repeat (4) tick();
      chk("q_wr_empty",  q_wr.size(),  0);
      chk("q_gnt_empty", q_gnt.size(), 0);
      chk("q_val_empty", q_val.size(), 0);
      chk("q_err_empty", q_err.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
